tmds_encode_mc: RTL and testbench
=================================

TMDS_ENCODE_MC -- requirements
Module: tmds_encode_mc

Interface
REQ-001 SHALL have parameter NCH, default 3: number of encoded lanes.
REQ-002 SHALL have parameter CNT_W, default 5: width of the signed running-disparity counter per lane, minimum 5.
REQ-003 SHALL have port clkin, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rstin, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port ce, input, 1: pipeline advance enable.
REQ-006 SHALL have port mode, input, 2: period type shared by all lanes; 00 control, 01 video, 10 TERC4 data island, 11 video guard band.
REQ-007 SHALL have port din, input, NCH*8: video bytes, with lane k in bits [8k+7:8k].
REQ-008 SHALL have port ctl, input, NCH*2: control pair {c1,c0} per lane, with lane k in bits [2k+1:2k].
REQ-009 SHALL have port terc, input, NCH*4: TERC4 nibble per lane, with lane k in bits [4k+3:4k].
REQ-010 SHALL have port dout, output, NCH*10: encoded symbol per lane, with lane k in bits [10k+9:10k].

Function
REQ-011 SHALL register mode, din, ctl and terc on every ce=1 edge, and SHALL deliver the result on dout exactly 3 ce=1 edges later (3-stage pipeline).
REQ-012 Stage 1 SHALL register each lane's byte and its ones count n1d, 4 bits.
REQ-013 Stage 2 SHALL form q_m per lane using XNOR when (n1d>4) or (n1d==4 and d[0]==0), else XOR, with q_m[8]=~(XNOR chosen); SHALL register q_m with n1q = ones(q_m[7:0]) and n0q = 8-n1q.
REQ-014 Stage 3 in video mode SHALL apply the DVI 1.0 disparity rule per lane: if cnt==0 or n1q==n0q, dout={~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
REQ-015 In the REQ-014 case, cnt SHALL update by +(n0q-n1q) if q_m[8]==0, else by +(n1q-n0q).
REQ-016 Otherwise, if (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q), dout SHALL be {1, q_m[8], ~q_m[7:0]} and cnt SHALL update to cnt + 2*q_m[8] + (n0q-n1q).
REQ-017 Otherwise dout SHALL be {0, q_m[8], q_m[7:0]} and cnt SHALL update to cnt - 2*(~q_m[8]) + (n1q-n0q).
REQ-018 All cnt arithmetic SHALL be signed two's complement at CNT_W bits; the rule bounds |cnt| at or below 10, so no saturation SHALL be applied.
REQ-019 Control mode SHALL emit per {c1,c0}: 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
REQ-020 TERC4 mode SHALL emit the nibble mapping 0..F to: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
REQ-021 Guard-band mode SHALL emit 1011001100 on even-index lanes and 0100110011 on odd-index lanes.
REQ-022 All 10-bit symbols SHALL be written with bit 9 first (MSB first).
REQ-023 Any non-video symbol emitted SHALL clear that lane's cnt to 0 on the same edge.
REQ-024 A mode change SHALL take effect on a per-pixel basis, aligned through the pipeline: no symbol SHALL mix the mode of one pixel with the data of another.
REQ-025 ce=0 SHALL hold every pipeline register, cnt and dout unchanged; a mode change presented while ce=0 SHALL be ignored until sampled.
REQ-026 Lanes SHALL be fully independent except for the shared mode.

Reset
REQ-027 rstin=1 at an edge SHALL set dout to all zero, cnt to 0, and all pipeline mode registers to control mode with {c1,c0}=00, regardless of ce.
REQ-028 After rstin deasserts, the first 3 valid outputs SHALL be control token 1101010100 on every lane, until the first sampled input emerges.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight pixels.

Structure
REQ-030 A shared package tmds_pkg SHALL hold the mode encodings, the four control tokens, the TERC4 table and the two guard-band words.
REQ-031 One sub-module, tmds_lane, SHALL hold the stages 1-3 datapath and cnt for one lane, instantiated NCH times by generate.
REQ-032 The implementation target SHALL be 120-400 lines of RTL in total.

Verification
REQ-033 Reset followed by video mode with din=0x00 on all lanes for 3 pixels SHALL produce 0100000000, 1111111111, 0100000000 on every lane, with cnt sequence -8, +2, -6.
REQ-034 Control mode with ctl lane0=01, lane1=10, lane2=11 SHALL produce 0010101011, 0101010100, 1010101011 respectively, 3 cycles later.
REQ-035 TERC4 mode with nibbles 0x0, 0x8, 0xF SHALL produce 1010011100, 1011001100, 1011000011.
REQ-036 Video din=0x00 (cnt=-8), then one guard-band pixel, then din=0x00 SHALL produce guard 1011001100 / 0100110011, then 0100000000, proving the cnt clear.
REQ-037 Random stimulus with ce toggled at 50% SHALL produce a dout stream that, with the ce=0 cycles removed, is identical to the ce=1 reference model.
REQ-038 Random stimulus with rstin pulsed mid-stream SHALL produce all-zero dout in the reset cycle, then control tokens, and no stale pixels.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: period-type encodings, control tokens, TERC4 table,
// guard-band words and a byte ones-count helper.
package tmds_pkg;

   typedef enum logic [1:0] {
      MODE_CTL   = 2'b00,
      MODE_VID   = 2'b01,
      MODE_TERC  = 2'b10,
      MODE_GUARD = 2'b11
   } tmds_mode_e;

   localparam logic [9:0] CTL_TOK_00 = 10'b1101010100;
   localparam logic [9:0] CTL_TOK_01 = 10'b0010101011;
   localparam logic [9:0] CTL_TOK_10 = 10'b0101010100;
   localparam logic [9:0] CTL_TOK_11 = 10'b1010101011;

   localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
   localparam logic [9:0] GUARD_ODD  = 10'b0100110011;

   function automatic logic [9:0] ctl_token(input logic [1:0] c);
      logic [9:0] t;
      case (c)
         2'b00:   t = CTL_TOK_00;
         2'b01:   t = CTL_TOK_01;
         2'b10:   t = CTL_TOK_10;
         default: t = CTL_TOK_11;
      endcase
      return t;
   endfunction

   function automatic logic [9:0] terc4_sym(input logic [3:0] n);
      logic [9:0] t;
      case (n)
         4'h0:    t = 10'b1010011100;
         4'h1:    t = 10'b1001100011;
         4'h2:    t = 10'b1011100100;
         4'h3:    t = 10'b1011100010;
         4'h4:    t = 10'b0101110001;
         4'h5:    t = 10'b0100011110;
         4'h6:    t = 10'b0110001110;
         4'h7:    t = 10'b0100111100;
         4'h8:    t = 10'b1011001100;
         4'h9:    t = 10'b0100111001;
         4'hA:    t = 10'b0110011100;
         4'hB:    t = 10'b1011000110;
         4'hC:    t = 10'b1010001110;
         4'hD:    t = 10'b1001110001;
         4'hE:    t = 10'b0101100011;
         default: t = 10'b1011000011;
      endcase
      return t;
   endfunction

   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/tmds_encode_mc_if.sv
// Bundle of the encoder's per-pixel inputs and encoded output, for benches and
// wrappers that drive tmds_encode_mc as a unit.
interface tmds_encode_mc_if #(
   parameter int unsigned NCH = 3
);
   logic              ce;
   logic [1:0]        mode;
   logic [NCH*8-1:0]  din;
   logic [NCH*2-1:0]  ctl;
   logic [NCH*4-1:0]  terc;
   logic [NCH*10-1:0] dout;

   modport master (output ce, mode, din, ctl, terc, input dout);
   modport slave  (input ce, mode, din, ctl, terc, output dout);
endinterface

// File: rtl/tmds_lane.sv
// One TMDS lane: input capture, ones count, transition-minimising q_m and the
// DC-balancing / token stage with its running-disparity counter.
module tmds_lane
   import tmds_pkg::*;
#(
   parameter int unsigned LANE_IDX = 0,
   parameter int unsigned CNT_W    = 5
) (
   input  logic       clkin,
   input  logic       rstin,
   input  logic       ce,
   input  tmds_mode_e mode,
   input  logic [7:0] din,
   input  logic [1:0] ctl,
   input  logic [3:0] terc,
   output logic [9:0] dout
);

   // Mode, control pair and nibble travel with each pixel so a mode change
   // never pairs one pixel's period type with another pixel's data.
   tmds_mode_e mode0_q, mode0_d, mode1_q, mode1_d, mode2_q, mode2_d;
   logic [7:0] d0_q, d0_d, d1_q, d1_d;
   logic [1:0] ctl0_q, ctl0_d, ctl1_q, ctl1_d, ctl2_q, ctl2_d;
   logic [3:0] terc0_q, terc0_d, terc1_q, terc1_d, terc2_q, terc2_d;
   logic [3:0] n1d_q, n1d_d;
   logic [8:0] qm_q, qm_d;
   logic [3:0] n1q_q, n1q_d, n0q_q, n0q_d;
   logic [9:0] dout_q, dout_d;
   logic signed [CNT_W-1:0] cnt_q, cnt_d;

   logic                    use_xnor;
   logic signed [CNT_W-1:0] n1s, n0s, two_s;

   always_comb begin
      mode0_d  = mode;
      d0_d     = din;
      ctl0_d   = ctl;
      terc0_d  = terc;

      mode1_d  = mode0_q;
      d1_d     = d0_q;
      ctl1_d   = ctl0_q;
      terc1_d  = terc0_q;
      n1d_d    = ones8(d0_q);

      mode2_d  = mode1_q;
      ctl2_d   = ctl1_q;
      terc2_d  = terc1_q;
      use_xnor = (n1d_q > 4'd4) || ((n1d_q == 4'd4) && !d1_q[0]);
      qm_d     = '0;
      qm_d[0]  = d1_q[0];
      for (int unsigned i = 1; i < 8; i++) begin
         qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d1_q[i]) : (qm_d[i-1] ^ d1_q[i]);
      end
      qm_d[8]  = ~use_xnor;
      n1q_d    = ones8(qm_d[7:0]);
      n0q_d    = 4'd8 - n1q_d;
   end

   always_comb begin
      n1s    = signed'(CNT_W'(n1q_q));
      n0s    = signed'(CNT_W'(n0q_q));
      two_s  = signed'(CNT_W'(2));
      dout_d = ctl_token(ctl2_q);
      cnt_d  = '0;
      case (mode2_q)
         MODE_VID: begin
            if ((cnt_q == '0) || (n1q_q == n0q_q)) begin
               dout_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
               cnt_d  = qm_q[8] ? (cnt_q + n1s - n0s) : (cnt_q + n0s - n1s);
            // cnt is non-zero here, so its sign bit alone separates >0 from <0
            end else if ((!cnt_q[CNT_W-1] && (n1q_q > n0q_q)) ||
                         ( cnt_q[CNT_W-1] && (n0q_q > n1q_q))) begin
               dout_d = {1'b1, qm_q[8], ~qm_q[7:0]};
               cnt_d  = cnt_q + (qm_q[8] ? two_s : '0) + n0s - n1s;
            end else begin
               dout_d = {1'b0, qm_q[8], qm_q[7:0]};
               cnt_d  = cnt_q - (qm_q[8] ? '0 : two_s) + n1s - n0s;
            end
         end
         MODE_TERC:  dout_d = terc4_sym(terc2_q);
         MODE_GUARD: dout_d = (LANE_IDX % 2 == 1) ? GUARD_ODD : GUARD_EVEN;
         default:    dout_d = ctl_token(ctl2_q);
      endcase
   end

   always_ff @(posedge clkin) begin
      if (rstin) begin
         mode0_q <= MODE_CTL;
         mode1_q <= MODE_CTL;
         mode2_q <= MODE_CTL;
         d0_q    <= '0;
         d1_q    <= '0;
         ctl0_q  <= '0;
         ctl1_q  <= '0;
         ctl2_q  <= '0;
         terc0_q <= '0;
         terc1_q <= '0;
         terc2_q <= '0;
         n1d_q   <= '0;
         qm_q    <= '0;
         n1q_q   <= '0;
         n0q_q   <= '0;
         dout_q  <= '0;
         cnt_q   <= '0;
      end else if (ce) begin
         mode0_q <= mode0_d;
         mode1_q <= mode1_d;
         mode2_q <= mode2_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         ctl0_q  <= ctl0_d;
         ctl1_q  <= ctl1_d;
         ctl2_q  <= ctl2_d;
         terc0_q <= terc0_d;
         terc1_q <= terc1_d;
         terc2_q <= terc2_d;
         n1d_q   <= n1d_d;
         qm_q    <= qm_d;
         n1q_q   <= n1q_d;
         n0q_q   <= n0q_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/tmds_encode_mc.sv
// Multi-lane TMDS encoder: NCH independent lanes sharing one period-type input,
// each a pipeline with result on dout three ce edges after sampling.
module tmds_encode_mc
   import tmds_pkg::*;
#(
   parameter int unsigned NCH   = 3,
   parameter int unsigned CNT_W = 5
) (
   input  logic              clkin,
   input  logic              rstin,
   input  logic              ce,
   input  logic [1:0]        mode,
   input  logic [NCH*8-1:0]  din,
   input  logic [NCH*2-1:0]  ctl,
   input  logic [NCH*4-1:0]  terc,
   output logic [NCH*10-1:0] dout
);

   tmds_mode_e mode_e;

   always_comb begin
      mode_e = tmds_mode_e'(mode);
   end

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      tmds_lane #(
         .LANE_IDX (k),
         .CNT_W    (CNT_W)
      ) u_lane (
         .clkin (clkin),
         .rstin (rstin),
         .ce    (ce),
         .mode  (mode_e),
         .din   (din[8*k +: 8]),
         .ctl   (ctl[2*k +: 2]),
         .terc  (terc[4*k +: 4]),
         .dout  (dout[10*k +: 10])
      );
   end

endmodule

// File: tb/tb_tmds_encode_mc.sv
// Bench for tmds_encode_mc: directed literal sequences, then random traffic with
// ce gating and reset pulses, compared every cycle against a pixel-queue model.
module tb_tmds_encode_mc;

   localparam int NCH = 3;

   typedef struct {
      logic [1:0]        mode;
      logic [NCH*8-1:0]  din;
      logic [NCH*2-1:0]  ctl;
      logic [NCH*4-1:0]  terc;
   } pixel_t;

   logic clk;
   logic rstin;

   tmds_encode_mc_if #(.NCH(NCH)) bus ();

   tmds_encode_mc #(
      .NCH   (NCH),
      .CNT_W (5)
   ) dut (
      .clkin (clk),
      .rstin (rstin),
      .ce    (bus.ce),
      .mode  (bus.mode),
      .din   (bus.din),
      .ctl   (bus.ctl),
      .terc  (bus.terc),
      .dout  (bus.dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [9:0] ctl_tbl [4] = '{10'b1101010100, 10'b0010101011,
                               10'b0101010100, 10'b1010101011};
   logic [9:0] terc_tbl [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   pixel_t          pipe [$];
   pixel_t          px;
   pixel_t          cur;
   logic [NCH*10-1:0] exp_dout = '0;
   int              cnt_m [NCH];
   bit              model_ok = 0;

   task automatic enc_video(input logic [7:0] d, input int cin,
                            output logic [9:0] sym, output int cout);
      int n1, ones, zeros;
      bit xn, q8;
      logic [7:0] q;
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(d[i]);
      xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q8 = !xn;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(q[i]);
      zeros = 8 - ones;
      if (cin == 0 || ones == zeros) begin
         sym  = {~q8, q8, q8 ? q : ~q};
         cout = cin + (q8 ? ones - zeros : zeros - ones);
      end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
         sym  = {1'b1, q8, ~q};
         cout = cin + 2 * int'(q8) + zeros - ones;
      end else begin
         sym  = {1'b0, q8, q};
         cout = cin - 2 * int'(!q8) + ones - zeros;
      end
   endtask

   always @(posedge clk) begin
      if (rstin) begin
         exp_dout = '0;
         for (int k = 0; k < NCH; k++) cnt_m[k] = 0;
         pipe.delete();
         for (int i = 0; i < 3; i++) pipe.push_back('{2'b00, '0, '0, '0});
         model_ok = 1;
      end else if (bus.ce && model_ok) begin
         cur = '{bus.mode, bus.din, bus.ctl, bus.terc};
         pipe.push_back(cur);
         px = pipe.pop_front();
         for (int k = 0; k < NCH; k++) begin
            logic [9:0] sym;
            int         cn;
            case (px.mode)
               2'b01: begin
                  enc_video(px.din[8*k +: 8], cnt_m[k], sym, cn);
                  cnt_m[k] = cn;
               end
               2'b10: begin
                  sym = terc_tbl[px.terc[4*k +: 4]];
                  cnt_m[k] = 0;
               end
               2'b11: begin
                  sym = (k % 2 == 1) ? 10'b0100110011 : 10'b1011001100;
                  cnt_m[k] = 0;
               end
               default: begin
                  sym = ctl_tbl[px.ctl[2*k +: 2]];
                  cnt_m[k] = 0;
               end
            endcase
            exp_dout[10*k +: 10] = sym;
         end
      end
   end

   // ---------------- compare process ----------------
   bit                lit_en = 0;
   logic [NCH*10-1:0] lit_exp = '0;
   string             lit_name = "";

   always @(negedge clk) begin
      if (model_ok) begin
         checks++;
         if (bus.dout !== exp_dout) begin
            errors++;
            $display("FAIL model_cmp t=%0t dout=%b expected=%b", $time, bus.dout, exp_dout);
         end
      end
      if (lit_en) begin
         checks++;
         if (bus.dout !== lit_exp) begin
            errors++;
            $display("FAIL %s t=%0t dout=%b expected=%b", lit_name, $time, bus.dout, lit_exp);
         end
         checks++;
         if (exp_dout !== lit_exp) begin
            errors++;
            $display("FAIL model_pin_%s t=%0t model=%b expected=%b", lit_name, $time, exp_dout, lit_exp);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic r, input logic e, input logic [1:0] m,
                       input logic [23:0] d, input logic [5:0] c, input logic [11:0] t,
                       input bit chk, input logic [29:0] ex, input string nm);
      rstin    = r;
      bus.ce   = e;
      bus.mode = m;
      bus.din  = d;
      bus.ctl  = c;
      bus.terc = t;
      @(posedge clk);
      #1;
      lit_en   = chk;
      lit_exp  = ex;
      lit_name = nm;
   endtask

   function automatic logic [29:0] all3(input logic [9:0] s);
      return {s, s, s};
   endfunction

   localparam logic [29:0] CTL_LIT   = {10'b1010101011, 10'b0101010100, 10'b0010101011};
   localparam logic [29:0] TERC_LIT  = {10'b1011000011, 10'b1011001100, 10'b1010011100};
   localparam logic [29:0] GUARD_LIT = {10'b1011001100, 10'b0100110011, 10'b1011001100};

   initial begin
      rstin = 1'b1;
      bus.ce = 1'b0;
      bus.mode = 2'b00;
      bus.din = '0;
      bus.ctl = '0;
      bus.terc = '0;

      step(1, 0, 2'b00, 24'h0, 6'b0, 12'h0, 1, '0, "reset_zero");
      step(0, 1, 2'b01, 24'h0, 6'b0, 12'h0, 1, all3(10'b1101010100), "post_rst_ctl_1");
      step(0, 1, 2'b01, 24'h0, 6'b0, 12'h0, 1, all3(10'b1101010100), "post_rst_ctl_2");
      step(0, 1, 2'b01, 24'h0, 6'b0, 12'h0, 1, all3(10'b1101010100), "post_rst_ctl_3");
      step(0, 1, 2'b00, 24'h0, 6'b111001, 12'h0, 1, all3(10'b0100000000), "vid00_cnt_m8");
      step(0, 1, 2'b10, 24'h0, 6'b0, 12'hF80, 1, all3(10'b1111111111), "vid00_cnt_p2");
      step(0, 1, 2'b01, 24'h0, 6'b0, 12'h0, 1, all3(10'b0100000000), "vid00_cnt_m6");
      step(0, 1, 2'b11, 24'h0, 6'b0, 12'h0, 1, CTL_LIT, "ctl_tokens");
      step(0, 1, 2'b01, 24'h0, 6'b0, 12'h0, 1, TERC_LIT, "terc_0_8_f");
      step(0, 0, 2'b11, 24'hFFFFFF, 6'b0, 12'h0, 1, TERC_LIT, "ce_low_hold");
      step(0, 1, 2'b00, 24'h0, 6'b0, 12'h0, 1, all3(10'b0100000000), "vid_after_terc");
      step(0, 1, 2'b00, 24'h0, 6'b0, 12'h0, 1, GUARD_LIT, "guard_words");
      step(0, 1, 2'b00, 24'h0, 6'b0, 12'h0, 1, all3(10'b0100000000), "vid_after_guard");

      for (int i = 0; i < 3000; i++) begin
         logic       r, e;
         logic [1:0] m;
         r = ($urandom_range(0, 199) == 0);
         e = (i < 600) ? 1'b1 : 1'($urandom_range(0, 1));
         m = ($urandom_range(0, 9) < 6) ? 2'b01 : 2'($urandom_range(0, 3));
         step(r, e, m, 24'($urandom), 6'($urandom), 12'($urandom), r, '0, "rst_mid_zero");
      end

      step(0, 1, 2'b00, 24'h0, 6'b0, 12'h0, 0, '0, "");
      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
